// File: rtl/wav_tb_pkg.sv
// rtl/wav_tb_pkg.sv - shared types and widths for the WAV capture sequencer
package wav_tb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        PAD,
        FINISH,
        DONE,
        ERR
    } cap_state_t;

    localparam int FRAME_CNT_W = 32;

endpackage

// File: rtl/wav_tap_hold.sv
// rtl/wav_tap_hold.sv - one-entry holding register for a single audio tap
module wav_tap_hold #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] tdata,
    output logic                  tready,
    output logic                  held_valid,
    output logic [DATA_WIDTH-1:0] held_data,
    input  logic                  take
);

    // Ready comes only from the registered full flag, so a slot drained this
    // cycle cannot be refilled until the next one.
    assign tready = en & ~held_valid;

    // Capture on handshake, release when the sequencer takes the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= 1'b0;
            held_data  <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (tvalid && tready) begin
            held_valid <= 1'b1;
            held_data  <= tdata;
        end else if (take) begin
            held_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wav_capture_ctrl.sv
// rtl/wav_capture_ctrl.sv - sequences a WAV writer and interleaves audio taps frame by frame
module wav_capture_ctrl
    import wav_tb_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_FRAMES  = 48000,
    parameter int ARM_TIMEOUT = 1024,
    parameter int FINISH_HOLD = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [NUM_CH-1:0]            src_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] src_data,
    output logic [NUM_CH-1:0]            src_ready,
    output logic                         wr_enable,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic                         wr_finish,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [FRAME_CNT_W-1:0]       frame_count
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W = $clog2(ARM_TIMEOUT + 1);
    localparam int FH_W  = $clog2(FINISH_HOLD + 1);
    localparam logic [PTR_W-1:0]       LAST_PTR    = PTR_W'(NUM_CH - 1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_LIMIT = FRAME_CNT_W'(NUM_FRAMES);

    cap_state_t            state;
    cap_state_t            state_next;
    logic [PTR_W-1:0]      ptr;
    logic [TMO_W-1:0]      tmo;
    logic [FH_W-1:0]       fin_cnt;
    logic                  stop_req;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     take;
    logic [DATA_WIDTH-1:0] hold_data [NUM_CH];
    logic                  hold_en;
    logic                  flush;
    logic                  xfer;
    logic                  reached;
    logic                  at_end;
    logic                  start_ok;

    assign reached  = (NUM_FRAMES != 0) && (frame_count == FRAME_LIMIT);
    // A frame boundary with an end condition stops before ch0 of the next frame goes out.
    assign at_end   = (ptr == '0) && (stop_req || reached);
    assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign hold_en  = (state == RUN);
    assign flush    = (state == DONE);
    assign xfer     = wr_valid & wr_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_tap
        assign take[i] = xfer && (ptr == PTR_W'(i));
        wav_tap_hold #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_hold (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (hold_en),
            .flush      (flush),
            .tvalid     (src_valid[i]),
            .tdata      (src_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .tready     (src_ready[i]),
            .held_valid (full[i]),
            .held_data  (hold_data[i]),
            .take       (take[i])
        );
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer transitions.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = ARM;
            ARM: begin
                if (stop || stop_req)               state_next = FINISH;
                else if (wr_ready)                  state_next = RUN;
                else if (tmo == TMO_W'(ARM_TIMEOUT)) state_next = ERR;
            end
            RUN: begin
                if (at_end)
                    state_next = FINISH;
                // A stop landing on the last transfer of a frame waits for the boundary instead of padding.
                else if (stop_req && !(xfer && (ptr == LAST_PTR)))
                    state_next = PAD;
            end
            PAD:    if (xfer && (ptr == LAST_PTR)) state_next = FINISH;
            FINISH: if (fin_cnt == FH_W'(FINISH_HOLD - 1)) state_next = DONE;
            DONE:   if (start) state_next = ARM;
            ERR:    if (start) state_next = ARM;
            default: state_next = IDLE;
        endcase
    end

    // Writer-facing outputs decoded from state and the current channel slot.
    always_comb begin
        wr_enable = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        wr_finish = 1'b0;
        busy      = 1'b0;
        case (state)
            ARM: begin
                wr_enable = 1'b1;
                busy      = 1'b1;
            end
            RUN: begin
                wr_enable = 1'b1;
                busy      = 1'b1;
                wr_valid  = full[ptr] & ~at_end;
                if (full[ptr]) wr_data = hold_data[ptr];
            end
            PAD: begin
                wr_enable = 1'b1;
                busy      = 1'b1;
                wr_valid  = 1'b1;
                if (full[ptr]) wr_data = hold_data[ptr];
            end
            FINISH: begin
                busy      = 1'b1;
                wr_finish = 1'b1;
            end
            default: ;
        endcase
    end

    // Channel pointer, frame counter, timers, stop latch and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            frame_count <= '0;
            tmo         <= '0;
            fin_cnt     <= '0;
            stop_req    <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done    <= (state_next == DONE) && (state != DONE);
            tmo     <= (state == ARM) ? tmo + TMO_W'(1) : '0;
            fin_cnt <= (state == FINISH) ? fin_cnt + FH_W'(1) : '0;

            if ((state == ARM) || (state == RUN) || (state == PAD)) begin
                if (stop) stop_req <= 1'b1;
            end else begin
                stop_req <= 1'b0;
            end

            if (start_ok)
                err <= 1'b0;
            else if ((state == ARM) && (state_next == ERR))
                err <= 1'b1;

            if (start_ok) begin
                ptr         <= '0;
                frame_count <= '0;
            end else if (xfer) begin
                if (ptr == LAST_PTR) begin
                    ptr <= '0;
                    if (frame_count != '1) frame_count <= frame_count + FRAME_CNT_W'(1);
                end else begin
                    ptr <= ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wav_capture_ctrl.sv
// tb/tb_wav_capture_ctrl.sv - scoreboard bench for wav_capture_ctrl
module tb_wav_capture_ctrl;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int NFR = 120;
    localparam int ATO = 1024;
    localparam int FH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [NCH-1:0]    src_valid = '0;
    logic [NCH*DW-1:0] src_data = '0;
    logic [NCH-1:0]    src_ready;
    logic              wr_enable;
    logic [DW-1:0]     wr_data;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic              wr_finish;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       frame_count;

    always #5 clk = ~clk;

    wav_capture_ctrl #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .NUM_FRAMES(NFR),
        .ARM_TIMEOUT(ATO), .FINISH_HOLD(FH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .wr_enable(wr_enable), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_finish(wr_finish), .busy(busy),
        .done(done), .err(err), .frame_count(frame_count)
    );

    typedef enum int {F_WR_ENABLE, F_WR_VALID, F_WR_FINISH, F_BUSY, F_DONE, F_ERR,
                      F_FRAME_COUNT, F_SRC_READY, F_WR_DATA, F_NWRITES, F_TIMEOUT} fld_t;
    typedef struct {
        string  name;
        fld_t   fld;
        longint val;
    } exp_t;

    exp_t sq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: per-channel FIFOs of accepted samples; the writer must see
    // them interleaved ch0..ch3, with zeros allowed only once a stop was issued.
    int   rb [NCH][256];
    int   rh [NCH] = '{default: 0};
    int   rt [NCH] = '{default: 0};
    int   wptr = 0;
    int   nwrites = 0;
    int   fin_run = 0;
    bit   done_prev = 1'b0;
    bit   pad_ok = 1'b0;

    function automatic longint field(fld_t f);
        case (f)
            F_WR_ENABLE:   return longint'(wr_enable);
            F_WR_VALID:    return longint'(wr_valid);
            F_WR_FINISH:   return longint'(wr_finish);
            F_BUSY:        return longint'(busy);
            F_DONE:        return longint'(done);
            F_ERR:         return longint'(err);
            F_FRAME_COUNT: return longint'(frame_count);
            F_SRC_READY:   return longint'(src_ready);
            F_WR_DATA:     return longint'(wr_data);
            F_NWRITES:     return longint'(nwrites);
            default:       return 1;
        endcase
    endfunction

    task automatic cmp(input string name, input longint act, input longint exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) rh[i] = rt[i];
    endtask

    // Monitor: drains pending status expectations and checks every writer transfer.
    always @(negedge clk) begin : monitor
        exp_t   e;
        longint exp_d;
        while (sq.size() > 0) begin
            e = sq.pop_front();
            cmp(e.name, field(e.fld), e.val);
        end
        if (!rst_n) begin
            clear_model();
            wptr = 0;
            nwrites = 0;
            fin_run = 0;
            done_prev = 1'b0;
        end else begin
            if (start && !busy) begin
                clear_model();
                wptr = 0;
                nwrites = 0;
            end
            if (wr_finish) begin
                fin_run++;
                cmp("valid_during_finish", longint'(wr_valid), 0);
            end
            if (wr_valid && wr_ready) begin
                if (rh[wptr] != rt[wptr]) begin
                    exp_d = rb[wptr][rh[wptr] % 256];
                    rh[wptr]++;
                end else if (pad_ok) begin
                    exp_d = 0;
                end else begin
                    exp_d = -100000;
                end
                cmp($sformatf("wr_data ch%0d n%0d", wptr, nwrites), longint'(signed'(wr_data)), exp_d);
                wptr = (wptr + 1) % NCH;
                nwrites++;
            end
            for (int i = 0; i < NCH; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    rb[i][rt[i] % 256] = int'(signed'(src_data[i*DW +: DW]));
                    rt[i]++;
                end
            end
            if (done) begin
                cmp("done_single_cycle", longint'(done_prev), 0);
                cmp("finish_hold", fin_run, FH);
                cmp("frame_aligned", nwrites % NCH, 0);
                cmp("frame_count_vs_model", longint'(frame_count), nwrites / NCH);
                fin_run = 0;
                clear_model();
            end
            done_prev = done;
        end
    end

    task automatic expect_v(input string n, input fld_t f, input longint v);
        exp_t e;
        e.name = n;
        e.fld  = f;
        e.val  = v;
        sq.push_back(e);
    endtask

    task automatic expect_quiet(input string tag);
        expect_v({tag, " wr_enable"}, F_WR_ENABLE, 0);
        expect_v({tag, " wr_valid"}, F_WR_VALID, 0);
        expect_v({tag, " wr_finish"}, F_WR_FINISH, 0);
        expect_v({tag, " busy"}, F_BUSY, 0);
        expect_v({tag, " done"}, F_DONE, 0);
        expect_v({tag, " err"}, F_ERR, 0);
        expect_v({tag, " frame_count"}, F_FRAME_COUNT, 0);
        expect_v({tag, " src_ready"}, F_SRC_READY, 0);
        expect_v({tag, " wr_data"}, F_WR_DATA, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
    endtask

    function automatic logic [NCH*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic feed(input logic [NCH-1:0] mask, input logic [NCH*DW-1:0] data);
        logic [NCH-1:0] left;
        logic [NCH-1:0] acc;
        src_data  = data;
        src_valid = mask;
        left      = mask;
        for (int c = 0; c < 200 && left != '0; c++) begin
            @(negedge clk);
            acc = src_valid & src_ready;
            @(posedge clk);
            #1;
            left &= ~acc;
            src_valid = left;
        end
        if (left != '0) expect_v("feed timeout", F_TIMEOUT, 0);
        src_valid = '0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen = 1'b0;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) expect_v({tag, " done timeout"}, F_TIMEOUT, 0);
    endtask

    task automatic wait_writes(input int n, input int limit);
        for (int c = 0; c < limit && nwrites < n; c++) tick();
        if (nwrites < n) expect_v("write count timeout", F_TIMEOUT, 0);
    endtask

    task automatic rand_cycle();
        src_valid = NCH'($urandom());
        src_data  = {$urandom(), $urandom()};
        wr_ready  = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0;
        repeat (3) tick();
        expect_quiet("reset");
        tick();
        rst_n = 1'b1;
        wr_ready = 1'b1;

        // Start and stop together in IDLE, then two frames with an ignored start mid-run.
        tick(); start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        tick();
        expect_v("t1 busy after start", F_BUSY, 1);
        feed(4'hF, pack4(100, -1, 1000, -1000));
        pulse_start();
        expect_v("t1 busy after ignored start", F_BUSY, 1);
        feed(4'hF, pack4(200, -2, 2000, -2000));
        wait_writes(8, 50);
        pulse_stop();
        wait_done("t1", 50);
        expect_v("t1 frame_count", F_FRAME_COUNT, 2);
        expect_v("t1 writes", F_NWRITES, 8);

        // Stop after ch0 of frame 2: remaining channels pad with zeros.
        pulse_start();
        feed(4'hF, pack4(1, 2, 3, 4));
        feed(4'b0001, pack4(7, 0, 0, 0));
        wait_writes(5, 50);
        pad_ok = 1'b1;
        pulse_stop();
        wait_done("t2", 50);
        expect_v("t2 frame_count", F_FRAME_COUNT, 2);
        expect_v("t2 writes", F_NWRITES, 8);
        tick();
        pad_ok = 1'b0;

        // Held samples are sent in place of pad zeros.
        pulse_start();
        for (int c = 0; c < 20 && src_ready == '0; c++) tick();
        wr_ready = 1'b0;
        feed(4'b0111, pack4(11, 22, 33, 0));
        tick(); wr_ready = 1'b1;
        tick(); wr_ready = 1'b0;
        expect_v("t3 one write before stop", F_NWRITES, 1);
        pad_ok = 1'b1;
        pulse_stop();
        tick(); wr_ready = 1'b1;
        wait_done("t3", 50);
        expect_v("t3 frame_count", F_FRAME_COUNT, 1);
        expect_v("t3 writes", F_NWRITES, 4);
        tick();
        pad_ok = 1'b0;

        // Stop while still arming.
        wr_ready = 1'b0;
        pulse_start();
        tick(); tick();
        pulse_stop();
        wait_done("t4", 50);
        expect_v("t4 frame_count", F_FRAME_COUNT, 0);
        expect_v("t4 writes", F_NWRITES, 0);

        // Arm timeout, then restart clears err.
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            tick();
            if (err) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) expect_v("t5 err timeout", F_TIMEOUT, 0);
        tick();
        expect_v("t5 err", F_ERR, 1);
        expect_v("t5 wr_enable", F_WR_ENABLE, 0);
        expect_v("t5 busy", F_BUSY, 0);
        pulse_start();
        expect_v("t5 err cleared", F_ERR, 0);
        expect_v("t5 rearm wr_enable", F_WR_ENABLE, 1);
        pulse_stop();
        wait_done("t5", 50);

        // Random taps and throttled writer until the automatic frame limit.
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            tick();
            if (done) begin
                hit = 1'b1;
                break;
            end
            rand_cycle();
        end
        if (!hit) expect_v("t6 done timeout", F_TIMEOUT, 0);
        src_valid = '0;
        wr_ready  = 1'b1;
        expect_v("t6 frame_count", F_FRAME_COUNT, NFR);
        expect_v("t6 writes", F_NWRITES, NFR * NCH);

        // Asynchronous reset mid-run, then a fresh capture.
        pulse_start();
        for (int c = 0; c < 2000 && nwrites < 5 * NCH; c++) begin
            tick();
            rand_cycle();
        end
        if (nwrites < 5 * NCH) expect_v("t7 run timeout", F_TIMEOUT, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        src_valid = '0;
        expect_quiet("t7 reset");
        tick(); tick();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        pulse_start();
        feed(4'hF, pack4(9, -8, 7, -6));
        wait_writes(4, 50);
        pulse_stop();
        wait_done("t7", 50);
        expect_v("t7 frame_count", F_FRAME_COUNT, 1);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
